// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: parameterised register bank with one write port, two
// registered read ports (write-first bypass) and a sequential clear engine.
// While a clear sequence runs, writes and reads are locked out and busy is high.
module reg_bank_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             valid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             valid_b,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             valid_a_q, valid_a_d;
  logic             valid_b_q, valid_b_d;

  // Storage write port, shared by user writes and the clear engine.
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  // A user write that actually lands this cycle (drives the read bypass).
  logic             wr_en;

  // An address names real, writable/readable storage: inside the bank and
  // not the hard-wired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
  endfunction

  assign busy    = (state_q == CLEAR);
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;

  // Next-state logic: clear FSM, counter and storage write arbitration.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          // The clear wins over a write issued in the same cycle.
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (we && addr_ok(waddr)) begin
          wr_en  = 1'b1;
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reset beats everything, including storage updates on the same edge.
    if (reset) begin
      mem_we = 1'b0;
      wr_en  = 1'b0;
    end
  end

  // Read ports: registered, write-first bypass, locked out while clearing.
  always_comb begin
    rdata_a_d = rdata_a_q;
    valid_a_d = 1'b0;
    if (re_a && (state_q == IDLE)) begin
      valid_a_d = 1'b1;
      if (!addr_ok(raddr_a))                rdata_a_d = '0;
      else if (wr_en && (waddr == raddr_a)) rdata_a_d = wdata;
      else                                  rdata_a_d = mem_q[raddr_a];
    end
    rdata_b_d = rdata_b_q;
    valid_b_d = 1'b0;
    if (re_b && (state_q == IDLE)) begin
      valid_b_d = 1'b1;
      if (!addr_ok(raddr_b))                rdata_b_d = '0;
      else if (wr_en && (waddr == raddr_b)) rdata_b_d = wdata;
      else                                  rdata_b_d = mem_q[raddr_b];
    end
  end

  // Control and read-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  // Storage array update.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset branch; contents survive reset and only writes or the clear engine change them.
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: read results are predicted from a bench
// model into a scoreboard queue and compared one cycle later.
module tb_reg_bank_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we, re_a, re_b, clr_req;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata;

  logic [15:0] d_rdata_a, d_rdata_b, z_rdata_a, z_rdata_b;
  logic        d_valid_a, d_valid_b, z_valid_a, z_valid_b, d_busy, z_busy;

  logic        b_we, b_re_a, b_re_b, b_clr_req;
  logic [3:0]  b_waddr, b_raddr_a, b_raddr_b;
  logic [31:0] b_wdata, b_rdata_a, b_rdata_b;
  logic        b_valid_a, b_valid_b, b_busy;

  // Default bank.
  reg_bank_ctrl u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(d_rdata_a), .valid_a(d_valid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(d_rdata_b), .valid_b(d_valid_b),
    .clr_req(clr_req), .busy(d_busy)
  );

  // Zero-register bank with a non-power-of-two depth, sharing the stimulus.
  reg_bank_ctrl #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1)) u_zr (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(z_rdata_a), .valid_a(z_valid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(z_rdata_b), .valid_b(z_valid_b),
    .clr_req(clr_req), .busy(z_busy)
  );

  // Wide, deep bank.
  reg_bank_ctrl #(.WIDTH(32), .DEPTH(16)) u_big (
    .clk(clk), .reset(reset), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re_a(b_re_a), .raddr_a(b_raddr_a), .rdata_a(b_rdata_a), .valid_a(b_valid_a),
    .re_b(b_re_b), .raddr_b(b_raddr_b), .rdata_b(b_rdata_b), .valid_b(b_valid_b),
    .clr_req(b_clr_req), .busy(b_busy)
  );

  typedef enum int {S_DA, S_DB, S_DVA, S_DVB, S_ZA, S_ZB, S_ZVA, S_ZVB, S_BA, S_BVA} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_mem [8];
  logic [15:0] z_mem     [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_DA:    return 32'(d_rdata_a);
      S_DB:    return 32'(d_rdata_b);
      S_DVA:   return 32'(d_valid_a);
      S_DVB:   return 32'(d_valid_b);
      S_ZA:    return 32'(z_rdata_a);
      S_ZB:    return 32'(z_rdata_b);
      S_ZVA:   return 32'(z_valid_a);
      S_ZVB:   return 32'(z_valid_b);
      S_BA:    return b_rdata_a;
      S_BVA:   return 32'(b_valid_a);
      default: return 32'hDEAD_0000;
    endcase
  endfunction

  task automatic expect_out(input string tag, input sig_e s, input logic [31:0] e);
    exp_t it;
    it.tag = tag;
    it.sig = s;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, then the
  // scoreboard entries predicted for this edge are retired.
  task automatic step();
    exp_t it;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check(it.tag, observe(it.sig), it.exp);
    end
  endtask

  function automatic logic [15:0] z_exp(input logic [2:0] a);
    return ((a == 3'd0) || (a >= 3'd6)) ? 16'h0 : z_mem[a];
  endfunction

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clr_req = 1'b0;
    b_we = 1'b0; b_waddr = '0; b_wdata = '0;
    b_re_a = 1'b0; b_raddr_a = '0; b_re_b = 1'b0; b_raddr_b = '0; b_clr_req = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
    model_mem[a] = d;
    if (a != 3'd0 && a < 3'd6) z_mem[a] = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b, input string tag, input bit chk_z);
    re_a = 1'b1; raddr_a = a; re_b = 1'b1; raddr_b = b;
    expect_out({tag, "_da"}, S_DA, 32'(model_mem[a]));
    expect_out({tag, "_db"}, S_DB, 32'(model_mem[b]));
    expect_out({tag, "_dva"}, S_DVA, 32'd1);
    expect_out({tag, "_dvb"}, S_DVB, 32'd1);
    if (chk_z) begin
      expect_out({tag, "_za"}, S_ZA, 32'(z_exp(a)));
      expect_out({tag, "_zb"}, S_ZB, 32'(z_exp(b)));
      expect_out({tag, "_zva"}, S_ZVA, 32'd1);
      expect_out({tag, "_zvb"}, S_ZVB, 32'd1);
    end
    step();
    re_a = 1'b0; re_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    idle_inputs();
    for (int i = 0; i < 8; i++) z_mem[i] = '0;

    // Reset state.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_rdata_a", 32'(d_rdata_a), 32'h0);
    check("rst_rdata_b", 32'(d_rdata_b), 32'h0);
    check("rst_valid_a", 32'(d_valid_a), 32'h0);
    check("rst_valid_b", 32'(d_valid_b), 32'h0);
    check("rst_busy", 32'(d_busy), 32'h0);
    check("rst_big_busy", 32'(b_busy), 32'h0);
    check("rst_big_rdata_a", b_rdata_a, 32'h0);

    // Write reg i = i+1, then read A=3, B=7.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i + 1));
    rd(3'd3, 3'd7, "wr_rd_3_7", 1'b1);
    rd(3'd1, 3'd5, "wr_rd_1_5", 1'b1);

    // Zero register and out-of-range reads on the ZERO_REG bank.
    wr(3'd0, 16'h1234);
    rd(3'd0, 3'd6, "zero_reg", 1'b1);

    // No request: valid drops, data holds.
    expect_out("hold_da", S_DA, 32'h1234);
    expect_out("hold_dva", S_DVA, 32'h0);
    expect_out("hold_zva", S_ZVA, 32'h0);
    step();

    // Write-first bypass on both ports.
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd5;
    expect_out("bypass_da", S_DA, 32'hBEEF);
    expect_out("bypass_db", S_DB, 32'hBEEF);
    expect_out("bypass_za", S_ZA, 32'hBEEF);
    model_mem[5] = 16'hBEEF;
    z_mem[5] = 16'hBEEF;
    step();
    idle_inputs();
    rd(3'd5, 3'd2, "after_bypass", 1'b1);

    // Clear sequence with writes and reads attempted throughout.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    clr_req = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'h1111;
    re_a = 1'b1; raddr_a = 3'd1;
    expect_out("clr_start_da", S_DA, 32'hFFFF);
    expect_out("clr_start_dva", S_DVA, 32'h1);
    step();
    check("clr_busy_start", 32'(d_busy), 32'h1);
    clr_req = 1'b0; we = 1'b1; waddr = 3'd3; wdata = 16'h5555;
    re_a = 1'b1; raddr_a = 3'd3;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("clr_busy_%0d", k), 32'(d_busy), 32'(k < 8));
      check($sformatf("clr_zbusy_%0d", k), 32'(z_busy), 32'(k < 6));
      if (k < 8) begin
        check($sformatf("clr_valid_%0d", k), 32'(d_valid_a), 32'h0);
        check($sformatf("clr_hold_%0d", k), 32'(d_rdata_a), 32'hFFFF);
      end
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    for (int i = 0; i < 4; i++) rd(3'(i), 3'(7 - i), $sformatf("after_clr_%0d", i), 1'b0);

    // Reset three cycles into a clear; the write beside clr_req is dropped.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hAAAA);
    clr_req = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 16'h1234;
    step();
    check("rmc_busy_start", 32'(d_busy), 32'h1);
    idle_inputs();
    step();
    step();
    step();
    reset = 1'b1; re_a = 1'b1; raddr_a = 3'd4; we = 1'b1; waddr = 3'd6; wdata = 16'h7777;
    step();
    reset = 1'b0;
    idle_inputs();
    check("rmc_busy", 32'(d_busy), 32'h0);
    check("rmc_valid_a", 32'(d_valid_a), 32'h0);
    check("rmc_rdata_a", 32'(d_rdata_a), 32'h0);
    for (int i = 0; i < 3; i++) model_mem[i] = '0;
    for (int i = 0; i < 4; i++) rd(3'(i), 3'(7 - i), $sformatf("rmc_rd_%0d", i), 1'b0);

    // Wide/deep bank: top register round trip, then a 16-cycle clear.
    b_we = 1'b1; b_waddr = 4'd15; b_wdata = 32'hDEADBEEF;
    step();
    b_we = 1'b0;
    b_re_a = 1'b1; b_raddr_a = 4'd15;
    expect_out("big_rd15", S_BA, 32'hDEADBEEF);
    expect_out("big_vld15", S_BVA, 32'h1);
    step();
    b_re_a = 1'b0;
    b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    cnt = 0;
    while (b_busy && cnt < 40) begin
      cnt++;
      step();
    end
    check("big_clear_cycles", 32'(cnt), 32'd16);
    b_re_a = 1'b1; b_raddr_a = 4'd15;
    expect_out("big_rd15_cleared", S_BA, 32'h0);
    step();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
